// File: rtl/maxnet_engine.sv
// Iterative MAXNET winner-take-all engine, serial datapath, one multiplier.
// Ports: clk, rst_n, start, epsilon, a_in -> busy, done, out, out_idx, winner, timeout.
// Build option MAXNET_ITER_OUT_EN adds output iter_cnt[15:0] (iterations executed).
module maxnet_engine #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int MAX_ITER = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [W-1:0]         epsilon,
  input  logic [N*W-1:0]       a_in,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         out,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 winner,
  output logic                 timeout
`ifdef MAXNET_ITER_OUT_EN
  ,
  output logic [15:0]          iter_cnt
`endif
);

  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;
  localparam int SW = W + IW;
  localparam int PW = W + SW;

  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, ACCUM, UPDATE, DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   a [N];
  logic [W-1:0]   eps;
  logic [SW-1:0]  s;
  logic [IW-1:0]  k;
  logic [15:0]    iter;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  fidx;
  logic [W-1:0]   fval;
  logic           first;

  // Scan of the register file; only consulted for the first CHECK
  // after LOAD, later CHECKs use the counts gathered during UPDATE.
  logic [CW-1:0]  scnt;
  logic [IW-1:0]  sidx;
  logic [W-1:0]   sval;
  logic           sfound;

  always_comb begin
    scnt   = '0;
    sidx   = '0;
    sval   = '0;
    sfound = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (a[i] != '0) begin
        scnt = scnt + 1'b1;
        if (!sfound) begin
          sfound = 1'b1;
          sidx   = IW'(i);
          sval   = a[i];
        end
      end
    end
  end

  logic [CW-1:0]  cc;
  logic [IW-1:0]  ci;
  logic [W-1:0]   cv;

  assign cc = first ? scnt : cnt;
  assign ci = first ? sidx : fidx;
  assign cv = first ? sval : fval;

  // Shared update datapath: S is frozen, so every element sees
  // iteration-t values even though they are rewritten serially.
  logic [SW-1:0]  diff;
  logic [PW-1:0]  prod;
  logic [PW-1:0]  p;
  logic [W-1:0]   na;

  assign diff = s - SW'(a[k]);
  assign prod = PW'(eps) * PW'(diff);
  assign p    = prod >> FRAC;
  assign na   = (PW'(a[k]) > p) ? a[k] - p[W-1:0] : '0;

  logic last;
  assign last = (k == IW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      for (int i = 0; i < N; i++) a[i] <= '0;
      eps     <= '0;
      s       <= '0;
      k       <= '0;
      iter    <= '0;
      cnt     <= '0;
      fidx    <= '0;
      fval    <= '0;
      first   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
      out_idx <= '0;
      winner  <= 1'b0;
      timeout <= 1'b0;
`ifdef MAXNET_ITER_OUT_EN
      iter_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            busy    <= 1'b1;
            out     <= '0;
            out_idx <= '0;
            winner  <= 1'b0;
            timeout <= 1'b0;
`ifdef MAXNET_ITER_OUT_EN
            iter_cnt <= '0;
`endif
          end
        end
        LOAD: begin
          for (int i = 0; i < N; i++) a[i] <= a_in[i*W +: W];
          eps   <= epsilon;
          iter  <= '0;
          first <= 1'b1;
          state <= CHECK;
        end
        CHECK: begin
          if (cc <= CW'(1) || iter == 16'(MAX_ITER)) begin
            state   <= DONE;
            out     <= (cc == '0) ? '0 : cv;
            out_idx <= (cc == '0) ? '0 : ci;
            winner  <= (cc == CW'(1));
            timeout <= (cc > CW'(1));
`ifdef MAXNET_ITER_OUT_EN
            iter_cnt <= iter;
`endif
          end else begin
            state <= ACCUM;
            s     <= '0;
            k     <= '0;
            iter  <= iter + 16'd1;
            cnt   <= '0;
            fidx  <= '0;
            fval  <= '0;
            first <= 1'b0;
          end
        end
        ACCUM: begin
          s <= s + SW'(a[k]);
          if (last) begin
            k     <= '0;
            state <= UPDATE;
          end else begin
            k <= k + 1'b1;
          end
        end
        UPDATE: begin
          a[k] <= na;
          if (na != '0) begin
            cnt <= cnt + 1'b1;
            // Ascending k: the first hit is the lowest index.
            if (cnt == '0) begin
              fidx <= k;
              fval <= na;
            end
          end
          if (last) begin
            k     <= '0;
            state <= CHECK;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_engine.sv
// Self-checking bench for maxnet_engine (N=4, W=16, FRAC=8, MAX_ITER=20).
// Table vectors, hand sequences and random runs against a reference model.
module tb_maxnet_engine;

  localparam int MI = 20;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] epsilon;
  logic [63:0] a_in;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic [1:0]  out_idx;
  logic        winner;
  logic        timeout;
`ifdef MAXNET_ITER_OUT_EN
  logic [15:0] iter_cnt;
`endif

  maxnet_engine #(
    .N(4), .W(16), .FRAC(8), .MAX_ITER(MI)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .epsilon(epsilon),
    .a_in(a_in),
    .busy(busy),
    .done(done),
    .out(out),
    .out_idx(out_idx),
    .winner(winner),
    .timeout(timeout)
`ifdef MAXNET_ITER_OUT_EN
    ,
    .iter_cnt(iter_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] av;
    logic [15:0] e;
    int          xo;
    int          xi;
    int          xw;
    int          xt;
    int          xit;
  } vec_t;

  // Reference: apply the MAXNET rule to the whole vector per iteration.
  function automatic void model(input logic [63:0] av, input logic [15:0] e,
                                output int mo, output int mi, output int mw,
                                output int mt, output int mit);
    longint x[4];
    longint y[4];
    longint sum;
    longint p;
    int c;
    int lo;
    for (int i = 0; i < 4; i++) x[i] = longint'(av[i*16 +: 16]);
    mit = 0;
    while (1) begin
      c  = 0;
      lo = -1;
      for (int i = 0; i < 4; i++) begin
        if (x[i] != 0) begin
          c++;
          if (lo < 0) lo = i;
        end
      end
      if (c <= 1 || mit == MI) break;
      sum = 0;
      for (int i = 0; i < 4; i++) sum += x[i];
      for (int i = 0; i < 4; i++) begin
        p    = (longint'(e) * (sum - x[i])) / 256;
        y[i] = (x[i] > p) ? x[i] - p : 0;
      end
      x = y;
      mit++;
    end
    mo = (c == 0) ? 0 : int'(x[lo]);
    mi = (c == 0) ? 0 : lo;
    mw = (c == 1) ? 1 : 0;
    mt = (c > 1) ? 1 : 0;
  endfunction

  task automatic apply(input string nm, input logic [63:0] av,
                       input logic [15:0] e, input int xo, input int xi,
                       input int xw, input int xt, input int xit);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; a_in = av; epsilon = e;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, ".busy"}, busy, 1);
    cyc  = 0;
    seen = 0;
    while (cyc < 1000 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1;
    end
    chk({nm, ".done_seen"}, seen, 1);
    chk({nm, ".latency"}, cyc, 3 + xit * 9);
    chk({nm, ".out"}, out, xo);
    chk({nm, ".out_idx"}, out_idx, xi);
    chk({nm, ".winner"}, winner, xw);
    chk({nm, ".timeout"}, timeout, xt);
    chk({nm, ".busy_end"}, busy, 0);
`ifdef MAXNET_ITER_OUT_EN
    chk({nm, ".iter_cnt"}, iter_cnt, xit);
`endif
    @(posedge clk); #1;
    chk({nm, ".done_pulse"}, done, 0);
  endtask

  vec_t tbl[7];
  logic [63:0] v1;

  initial begin
    int mo, mi, mw, mt, mit;
    int ndone;
    logic [63:0] rv;
    logic [15:0] re;

    v1 = {16'd40, 16'd30, 16'd20, 16'd10};
    tbl[0] = '{v1, 16'h0040, 21, 3, 1, 0, 4};
    tbl[1] = '{64'd0, 16'h0040, 0, 0, 0, 0, 0};
    tbl[2] = '{{16'd0, 16'd77, 16'd0, 16'd0}, 16'h0040, 77, 2, 1, 0, 0};
    tbl[3] = '{{16'd0, 16'd0, 16'd50, 16'd50}, 16'h0040, 3, 0, 0, 1, MI};
    tbl[4] = '{{16'd8, 16'd7, 16'd6, 16'd5}, 16'h0100, 0, 0, 0, 0, 1};
    tbl[5] = '{{16'hFFFF, 16'd0, 16'd0, 16'd0}, 16'h0040, 65535, 3, 1, 0, 0};
    tbl[6] = '{{16'd0, 16'd0, 16'd5, 16'd5}, 16'h0000, 5, 0, 0, 1, MI};

    rst_n = 1'b0; start = 1'b0; epsilon = '0; a_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.out", out, 0);
    chk("rst.out_idx", out_idx, 0);
    chk("rst.winner", winner, 0);
    chk("rst.timeout", timeout, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      apply($sformatf("tbl%0d", i), tbl[i].av, tbl[i].e, tbl[i].xo,
            tbl[i].xi, tbl[i].xw, tbl[i].xt, tbl[i].xit);

    // Reset asserted while the first iteration is in UPDATE.
    @(posedge clk); #1;
    start = 1'b1; a_in = v1; epsilon = 16'h0040;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.out", out, 0);
    chk("abort.winner", winner, 0);
    ndone = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort.no_done", ndone, 0);
    rst_n = 1'b1;
    apply("after_abort", v1, 16'h0040, 21, 3, 1, 0, 4);

    // Second start while busy must be ignored.
    @(posedge clk); #1;
    start = 1'b1; a_in = v1; epsilon = 16'h0040;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; a_in = {16'd0, 16'd0, 16'd0, 16'd9}; epsilon = 16'h0000;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk("busy_start.out", out, 21);
        chk("busy_start.out_idx", out_idx, 3);
        chk("busy_start.winner", winner, 1);
      end
    end
    chk("busy_start.pulses", ndone, 1);

    // Randomised runs against the reference model.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++)
        rv[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'd0
                         : 16'($urandom_range(1, 300));
      if (r % 5 == 0) rv[31:16] = rv[15:0];
      re = 16'($urandom_range(0, 128));
      model(rv, re, mo, mi, mw, mt, mit);
      apply($sformatf("rnd%0d", r), rv, re, mo, mi, mw, mt, mit);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
